cpu_run_controller: RTL and testbench

CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

---
 rtl/cpu_run_controller.sv | 150 +++++++++++++++
 tb/tb_cpu_run_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// Run/pause/single-step controller for a CPU clock enable, driven by three raw,
// asynchronous push-buttons that are synchronised and debounced on the way in.
module cpu_run_controller #(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             inc,
    input  logic             cpu_halt,
    output logic             enable_control,
    output logic             start_control,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned DB_W      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned NBTN      = 3;
    localparam int unsigned BTN_START = 0;
    localparam int unsigned BTN_STOP  = 1;
    localparam int unsigned BTN_INC   = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_STEP  = 3'd4
    } state_e;

    logic [NBTN-1:0] raw_btn;
    logic [NBTN-1:0] sync1_q, sync2_q;
    logic [NBTN-1:0] db_q, db_d, db_prev_q;
    logic [DB_W-1:0] db_cnt_q [NBTN];
    logic [DB_W-1:0] db_cnt_d [NBTN];
    logic [NBTN-1:0] btn_ev;
    logic            ev_stop, ev_start, ev_inc;

    state_e           state_q, state_d;
    logic             enable_q, enable_d;
    logic             start_q, start_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign raw_btn = {inc, stop, start};

    // Debounce: adopt the synchronised level only after DB_CYCLES consecutive differing samples
    always_comb begin
        for (int i = 0; i < int'(NBTN); i++) begin
            db_d[i]     = db_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < int'(NBTN); i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= raw_btn;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            for (int i = 0; i < int'(NBTN); i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // Rising-edge events with stop > start > inc; losers in the same cycle are dropped
    assign btn_ev   = db_q & ~db_prev_q;
    assign ev_stop  = btn_ev[BTN_STOP];
    assign ev_start = btn_ev[BTN_START] & ~btn_ev[BTN_STOP];
    assign ev_inc   = btn_ev[BTN_INC] & ~btn_ev[BTN_STOP] & ~btn_ev[BTN_START];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            enable_q <= 1'b0;
            start_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            start_q  <= start_d;
            count_q  <= count_d;
        end
    end

    // Next state; outputs are decoded from the next state so they register cleanly
    always_comb begin
        state_d  = state_q;
        enable_d = 1'b0;
        start_d  = 1'b0;
        count_d  = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (ev_start) state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cpu_halt)     state_d = S_IDLE;
                else if (ev_stop) state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (cpu_halt)      state_d = S_IDLE;
                else if (ev_stop)  state_d = S_PAUSE;
                else if (ev_start) state_d = S_RUN;
                else if (ev_inc)   state_d = S_STEP;
            end
            S_STEP: begin
                state_d = S_PAUSE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        enable_d = (state_d == S_RUN) || (state_d == S_STEP);
        start_d  = (state_d == S_LOAD);

        if (state_d == S_LOAD) begin
            count_d = '0;
        end else if (enable_q) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    assign enable_control = enable_q;
    assign start_control  = start_q;
    assign state          = state_q;
    assign cycle_count    = count_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller: stimulus queues hand-computed per-cycle
// expectations; a negedge monitor pops and compares them against the DUT outputs.
module tb_cpu_run_controller;

    localparam int unsigned DB = 4;
    localparam int unsigned CW = 16;

    logic          clock    = 1'b0;
    logic          reset    = 1'b0;
    logic          start    = 1'b0;
    logic          stop     = 1'b0;
    logic          inc      = 1'b0;
    logic          cpu_halt = 1'b0;
    logic          enable_control;
    logic          start_control;
    logic [2:0]    state;
    logic [CW-1:0] cycle_count;

    cpu_run_controller #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .inc            (inc),
        .cpu_halt       (cpu_halt),
        .enable_control (enable_control),
        .start_control  (start_control),
        .state          (state),
        .cycle_count    (cycle_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int    checks = 0;
    int    errors = 0;
    int    q_cyc[$];
    int    q_st[$];
    int    q_en[$];
    int    q_sc[$];
    int    q_cnt[$];
    string q_name[$];

    task automatic exp_at(input int c, input int st, input int en, input int sc,
                          input int cnt, input string name);
        q_cyc.push_back(c);
        q_st.push_back(st);
        q_en.push_back(en);
        q_sc.push_back(sc);
        q_cnt.push_back(cnt);
        q_name.push_back(name);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #2;
        end
    endtask

    // Monitor: exclusivity every cycle, plus any scoreboard entries due this cycle
    always @(negedge clock) begin
        int    c, st, en, sc, cnt;
        string nm;
        checks++;
        if (enable_control && start_control) begin
            errors++;
            $display("FAIL excl cyc=%0d got en=%0b sc=%0b required not both high",
                     cyc, enable_control, start_control);
        end
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            c   = q_cyc.pop_front();
            st  = q_st.pop_front();
            en  = q_en.pop_front();
            sc  = q_sc.pop_front();
            cnt = q_cnt.pop_front();
            nm  = q_name.pop_front();
            checks++;
            if (c < cyc) begin
                errors++;
                $display("FAIL %s expectation for cyc=%0d not sampled (now %0d)", nm, c, cyc);
            end else if (state !== 3'(st) || enable_control !== 1'(en) ||
                         start_control !== 1'(sc) || cycle_count !== CW'(cnt)) begin
                errors++;
                $display("FAIL %s cyc=%0d got st=%0d en=%0b sc=%0b cnt=%h required st=%0d en=%0d sc=%0d cnt=%h",
                         nm, cyc, state, enable_control, start_control, cycle_count,
                         st, en, sc, CW'(cnt));
            end
        end
    end

    initial begin
        int k, p, q, s, h, b, e, r, t, u, c1, base, base2, base3, base4;

        exp_at(2, 0, 0, 0, 0, "reset_state");
        wait_to(3);
        reset = 1'b1;

        // Clean start from IDLE: LOAD 7 clocks after the press, then RUN
        wait_to(5);
        k    = cyc;
        base = k + 8;
        exp_at(k + 6,  0, 0, 0, 0, "start_latency");
        exp_at(k + 7,  1, 0, 1, 0, "load_pulse");
        exp_at(k + 8,  2, 1, 0, 0, "run_entry");
        exp_at(k + 9,  2, 1, 0, 1, "run_cnt1");
        exp_at(k + 10, 2, 1, 0, 2, "run_cnt2");
        exp_at(k + 11, 2, 1, 0, 3, "run_cnt3");
        start = 1'b1;
        wait_to(k + 10);
        start = 1'b0;
        wait_to(k + 18);

        // Stop, then three single steps
        p  = cyc;
        c1 = p + 7 - base;
        exp_at(p + 6, 2, 1, 0, p + 6 - base, "stop_latency");
        exp_at(p + 7, 3, 0, 0, c1, "paused");
        stop = 1'b1;
        wait_to(p + 10);
        stop = 1'b0;
        wait_to(p + 18);
        for (int i = 0; i < 3; i++) begin
            q = cyc;
            exp_at(q + 6, 3, 0, 0, c1 + i,     "step_wait");
            exp_at(q + 7, 4, 1, 0, c1 + i,     "step_enable");
            exp_at(q + 8, 3, 0, 0, c1 + i + 1, "step_done");
            exp_at(q + 9, 3, 0, 0, c1 + i + 1, "step_single");
            inc = 1'b1;
            wait_to(q + 10);
            inc = 1'b0;
            wait_to(q + 18);
        end

        // Start and inc together in PAUSE: resume, no step, no start pulse
        s     = cyc;
        base2 = s + 7 - (c1 + 3);
        exp_at(s + 6, 3, 0, 0, c1 + 3, "pause_hold");
        exp_at(s + 7, 2, 1, 0, c1 + 3, "resume_no_step");
        exp_at(s + 8, 2, 1, 0, c1 + 4, "resume_count");
        start = 1'b1;
        inc   = 1'b1;
        wait_to(s + 10);
        start = 1'b0;
        inc   = 1'b0;
        wait_to(s + 18);

        // Halt in the same cycle as a stop event wins
        h = cyc;
        exp_at(h + 6, 2, 1, 0, h + 6 - base2, "pre_halt");
        exp_at(h + 7, 0, 0, 0, h + 7 - base2, "halt_over_stop");
        exp_at(h + 9, 0, 0, 0, h + 7 - base2, "idle_after_halt");
        stop = 1'b1;
        wait_to(h + 6);
        cpu_halt = 1'b1;
        wait_to(h + 7);
        cpu_halt = 1'b0;
        wait_to(h + 10);
        stop = 1'b0;
        wait_to(h + 18);

        // Bouncing start: one event, timed from the final rising edge
        b     = cyc;
        e     = b + 20;
        base3 = e + 8;
        exp_at(b + 10, 0, 0, 0, h + 7 - base2, "bounce_mid");
        exp_at(e + 6,  0, 0, 0, h + 7 - base2, "bounce_no_early");
        exp_at(e + 7,  1, 0, 1, 0, "bounce_load");
        exp_at(e + 8,  2, 1, 0, 0, "bounce_run");
        exp_at(e + 12, 2, 1, 0, 4, "bounce_run_cnt");
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            wait_to(b + 2 * (i + 1));
        end
        start = 1'b1;
        wait_to(e + 10);
        start = 1'b0;
        wait_to(e + 18);

        // Reset mid-RUN: enable drops within the cycle, no enable afterwards
        r = cyc;
        exp_at(r + 1,  2, 1, 0, r + 1 - base3, "pre_reset_run");
        exp_at(r + 2,  0, 0, 0, 0, "async_reset");
        exp_at(r + 8,  0, 0, 0, 0, "idle_after_reset");
        exp_at(r + 20, 0, 0, 0, 0, "no_enable_after_reset");
        wait_to(r + 2);
        reset = 1'b0;
        wait_to(r + 5);
        reset = 1'b1;
        wait_to(r + 21);

        // Start held through reset release: event 2+DB clocks after release
        t     = cyc;
        u     = t + 3;
        base4 = u + 8;
        exp_at(t + 1, 0, 0, 0, 0, "held_in_reset");
        exp_at(u + 6, 0, 0, 0, 0, "held_no_early");
        exp_at(u + 7, 1, 0, 1, 0, "held_load");
        exp_at(u + 8, 2, 1, 0, 0, "held_run");
        reset = 1'b0;
        start = 1'b1;
        wait_to(u);
        reset = 1'b1;
        wait_to(u + 10);
        start = 1'b0;

        // Counter wrap, then halt
        exp_at(base4 + 65534, 2, 1, 0, 65534, "cnt_fffe");
        exp_at(base4 + 65535, 2, 1, 0, 65535, "cnt_ffff");
        exp_at(base4 + 65536, 2, 1, 0, 0,     "cnt_wrap");
        exp_at(base4 + 65537, 0, 0, 0, 1,     "halt_idle");
        exp_at(base4 + 65539, 0, 0, 0, 1,     "halt_idle_hold");
        wait_to(base4 + 65536);
        cpu_halt = 1'b1;
        wait_to(base4 + 65537);
        cpu_halt = 1'b0;
        wait_to(base4 + 65542);

        while (q_cyc.size() > 0) begin
            errors++;
            $display("FAIL %s expectation for cyc=%0d never reached", q_name[0], q_cyc[0]);
            void'(q_cyc.pop_front());
            void'(q_st.pop_front());
            void'(q_en.pop_front());
            void'(q_sc.pop_front());
            void'(q_cnt.pop_front());
            void'(q_name.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
